// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the 5-stage MIPS pipeline.
// Used by the fetch stage and the stage registers.
package pipe_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } fetch_state_t;

  localparam word_t NOP_INSTR      = 32'h0000_0000;
  localparam word_t HALT_INSTR_DEF = 32'hFFFF_FFFF;
  localparam word_t PC_STEP        = 32'h0000_0004;

  // Width of the drain counter; wide enough for any sensible drain depth.
  localparam int unsigned CNT_W = 8;

  // Sequential fetch address; wraps modulo 2^32 by construction.
  function automatic word_t pc_incr(input word_t pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of hazard-unit, instruction-memory and decode-side signals of the fetch stage.
// The master modport is taken by the fetch stage itself.
interface fetch_stage_if;
  import pipe_pkg::*;

  logic  stallF;
  logic  stallD;
  logic  flush;
  word_t pc_branchM;
  word_t instr_in;
  word_t pc_out;
  word_t instrD;
  word_t pc_plus4D;
  logic  validD;
  logic  halt_stall;
  logic  done;

  modport master (
    input  stallF, stallD, flush, pc_branchM, instr_in,
    output pc_out, instrD, pc_plus4D, validD, halt_stall, done
  );

  modport slave (
    output stallF, stallD, flush, pc_branchM, instr_in,
    input  pc_out, instrD, pc_plus4D, validD, halt_stall, done
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall beats load, with a bubble request
// that loads a NOP with valid cleared instead of the incoming instruction.
module if_id_reg
  import pipe_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  flush,
  input  logic  stall,
  input  logic  bubble,
  input  word_t instr_in,
  input  word_t pc_plus4_in,
  output word_t instr_out,
  output word_t pc_plus4_out,
  output logic  valid_out
);

  word_t instr_r;
  word_t pc4_r;
  logic  valid_r;
  word_t instr_nxt_s;
  word_t pc4_nxt_s;
  logic  valid_nxt_s;

  // Next-value selection in priority order.
  always_comb begin
    instr_nxt_s = instr_r;
    pc4_nxt_s   = pc4_r;
    valid_nxt_s = valid_r;
    if (flush) begin
      instr_nxt_s = NOP_INSTR;
      pc4_nxt_s   = 32'h0000_0000;
      valid_nxt_s = 1'b0;
    end else if (stall) begin
      instr_nxt_s = instr_r;
      pc4_nxt_s   = pc4_r;
      valid_nxt_s = valid_r;
    end else if (bubble) begin
      instr_nxt_s = NOP_INSTR;
      pc4_nxt_s   = 32'h0000_0000;
      valid_nxt_s = 1'b0;
    end else begin
      instr_nxt_s = instr_in;
      pc4_nxt_s   = pc_plus4_in;
      valid_nxt_s = 1'b1;
    end
  end

  // Register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_r <= NOP_INSTR;
      pc4_r   <= 32'h0000_0000;
      valid_r <= 1'b0;
    end else begin
      instr_r <= instr_nxt_s;
      pc4_r   <= pc4_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  assign instr_out    = instr_r;
  assign pc_plus4_out = pc4_r;
  assign valid_out    = valid_r;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, halt detection/drain FSM, and the IF/ID register.
// After the halt word is fetched the pipeline drains, then done is raised until reset.
module fetch_stage
  import pipe_pkg::*;
#(
  parameter word_t       RESET_PC     = 32'h0000_0000,
  parameter word_t       HALT_INSTR   = HALT_INSTR_DEF,
  parameter int unsigned DRAIN_CYCLES = 4
)(
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  fetch_state_t     state_r;
  fetch_state_t     state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  word_t            pc_r;
  word_t            pc_nxt_s;
  word_t            pc_plus4_s;
  logic             halt_stall_r;
  logic             done_r;
  logic             halt_fetch_s;
  logic             id_bubble_s;
  logic             id_flush_s;
  logic             id_stall_s;

  assign pc_plus4_s   = pc_incr(pc_r);
  assign halt_fetch_s = (state_r == RUN) && (bus.instr_in == HALT_INSTR) &&
                        !bus.stallF && !bus.flush;

  // Next state, drain counter and PC; DONE ignores flush and stalls entirely.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    pc_nxt_s    = pc_r;
    case (state_r)
      RUN: begin
        if (bus.flush) begin
          pc_nxt_s = bus.pc_branchM;
        end else if (bus.stallF) begin
          pc_nxt_s = pc_r;
        end else if (halt_fetch_s) begin
          pc_nxt_s    = pc_r;
          state_nxt_s = DRAIN;
          cnt_nxt_s   = CNT_LOAD;
        end else begin
          pc_nxt_s = pc_plus4_s;
        end
      end
      DRAIN: begin
        if (bus.flush) begin
          // Halt was on a wrong path: resume fetching at the branch target.
          pc_nxt_s    = bus.pc_branchM;
          state_nxt_s = RUN;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (cnt_r == {CNT_W{1'b0}}) begin
          state_nxt_s = DONE;
        end else begin
          cnt_nxt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        state_nxt_s = DONE;
      end
      default: begin
        state_nxt_s = RUN;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter, PC and status flags; flags are decodes of the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= RUN;
      cnt_r        <= {CNT_W{1'b0}};
      pc_r         <= RESET_PC;
      halt_stall_r <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      pc_r         <= pc_nxt_s;
      halt_stall_r <= (state_nxt_s != RUN);
      done_r       <= (state_nxt_s == DONE);
    end
  end

  assign id_bubble_s = (state_r != RUN) || halt_fetch_s;
  assign id_flush_s  = bus.flush  && (state_r != DONE);
  assign id_stall_s  = bus.stallD && (state_r != DONE);

  if_id_reg u_if_id (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (id_flush_s),
    .stall        (id_stall_s),
    .bubble       (id_bubble_s),
    .instr_in     (bus.instr_in),
    .pc_plus4_in  (pc_plus4_s),
    .instr_out    (bus.instrD),
    .pc_plus4_out (bus.pc_plus4D),
    .valid_out    (bus.validD)
  );

  assign bus.pc_out     = pc_r;
  assign bus.halt_stall = halt_stall_r;
  assign bus.done       = done_r;

endmodule
